// File: rtl/mem_test_sequencer_pkg.sv
// Shared types and defaults for the RAM write/verify sequencer.
package mem_test_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StInit   = 3'd1,
    StWrite  = 3'd2,
    StPreset = 3'd3,
    StRead   = 3'd4,
    StDrain  = 3'd5,
    StDone   = 3'd6
  } state_e;

  localparam logic [7:0] DefaultPattern = 8'hA5;

endpackage

// File: rtl/mem_test_sequencer_rd_checker.sv
// One-deep read-compare pipeline with saturating error count and first-failure address capture.
module mem_test_sequencer_rd_checker #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;
  logic              mismatch;

  // rdata arrives the cycle after the read, aligned with the stored slot.
  assign mismatch = valid_q && (rdata != exp_q);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q        <= 1'b0;
      addr_q         <= '0;
      exp_q          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      valid_q <= push;
      addr_q  <= push_addr;
      exp_q   <= push_data;
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (err_count == '0) begin
          first_err_addr <= addr_q;
        end
      end
    end
  end

endmodule

// File: rtl/mem_test_sequencer.sv
// Drives an external address_generator to run one ascending write / descending verify RAM sweep.
module mem_test_sequencer
  import mem_test_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 4,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DefaultPattern),
  parameter int unsigned       ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              ag_reset,
  output logic              ag_preset,
  output logic              ag_en,
  output logic              ag_up_down,
  input  logic [ADDR_W-1:0] ag_address,
  input  logic              ag_carry,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              start_ok;
  logic              stay_done;
  logic [DATA_W-1:0] pattern_data;

  assign pattern_data = PATTERN ^ DATA_W'(ag_address);
  assign mem_addr     = ag_address;
  assign mem_wdata    = pattern_data;

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StInit;
          start_ok = 1'b1;
        end
      end
      StInit:   state_d = StWrite;
      StWrite:  if (ag_carry) state_d = StPreset;
      StPreset: state_d = StRead;
      StRead:   if (ag_carry) state_d = StDrain;
      StDrain:  state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  // done/pass register one cycle after entering DONE so they see the settled final count.
  assign stay_done = (state_q == StDone) && (state_d == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      ag_reset   <= 1'b0;
      ag_preset  <= 1'b0;
      ag_en      <= 1'b0;
      ag_up_down <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != StIdle) && !stay_done;
      done       <= stay_done;
      pass       <= stay_done && (err_count == '0);
      ag_reset   <= (state_d == StInit);
      ag_preset  <= (state_d == StPreset);
      ag_en      <= (state_d == StWrite) || (state_d == StRead);
      ag_up_down <= (state_d == StWrite);
      mem_we     <= (state_d == StWrite);
      mem_re     <= (state_d == StRead);
    end
  end

  mem_test_sequencer_rd_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ERR_W (ERR_W)
  ) u_rd_checker (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .push          (mem_re),
    .push_addr     (ag_address),
    .push_data     (pattern_data),
    .rdata         (mem_rdata),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench: sequencer + behavioural address generator + 16x8 RAM, plus an ERR_W=3 copy.
module tb_mem_test_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  int   fault_mode;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_pass;
  logic [7:0] a_err;
  logic [3:0] a_fea;
  logic       a_agr, a_agp, a_age, a_agud, a_carry;
  logic [3:0] a_addr, a_maddr;
  logic       a_we, a_re;
  logic [7:0] a_wdata, a_rdata;

  logic       b_busy, b_done, b_pass;
  logic [2:0] b_err;
  logic [3:0] b_fea;
  logic       b_agr, b_agp, b_age, b_agud, b_carry;
  logic [3:0] b_addr, b_maddr;
  logic       b_we, b_re;
  logic [7:0] b_wdata;

  mem_test_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_err_addr(a_fea), .ag_reset(a_agr), .ag_preset(a_agp),
    .ag_en(a_age), .ag_up_down(a_agud), .ag_address(a_addr), .ag_carry(a_carry),
    .mem_we(a_we), .mem_re(a_re), .mem_addr(a_maddr), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
  );

  mem_test_sequencer #(.ERR_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_err_addr(b_fea), .ag_reset(b_agr), .ag_preset(b_agp),
    .ag_en(b_age), .ag_up_down(b_agud), .ag_address(b_addr), .ag_carry(b_carry),
    .mem_we(b_we), .mem_re(b_re), .mem_addr(b_maddr), .mem_wdata(b_wdata), .mem_rdata(8'h00)
  );

  // Address generator models
  always @(posedge clk) begin
    if (reset || a_agr) a_addr <= 4'h0;
    else if (a_agp) a_addr <= 4'hF;
    else if (a_age) a_addr <= a_agud ? a_addr + 4'h1 : a_addr - 4'h1;
  end
  assign a_carry = a_agud ? (a_addr == 4'hF) : (a_addr == 4'h0);

  always @(posedge clk) begin
    if (reset || b_agr) b_addr <= 4'h0;
    else if (b_agp) b_addr <= 4'hF;
    else if (b_age) b_addr <= b_agud ? b_addr + 4'h1 : b_addr - 4'h1;
  end
  assign b_carry = b_agud ? (b_addr == 4'hF) : (b_addr == 4'h0);

  // RAM for dut_a with fault injection on the read path
  logic [7:0] ram [16];
  logic [7:0] ram_q;
  logic [3:0] rd_addr_q;
  always @(posedge clk) begin
    if (a_we) ram[a_maddr] <= a_wdata;
    if (a_re) begin
      ram_q     <= ram[a_maddr];
      rd_addr_q <= a_maddr;
    end
  end
  assign a_rdata = (fault_mode == 2) ? 8'h00 :
                   ((fault_mode == 1) && (rd_addr_q == 4'd9)) ? (ram_q ^ 8'h01) : ram_q;

  // Per-sweep observations
  int n_we, n_re, n_pre, pre_cyc, last_we_cyc, first_re_cyc, bad_wdata, busy_c0;
  int first_re_addr, last_re_addr, last_we_addr;

  // Starts from a negedge; lat = cycles from start-sampling edge to done, -1 on timeout.
  task automatic run_sweep(input int repulse_at, output int lat);
    n_we = 0; n_re = 0; n_pre = 0; pre_cyc = -1; last_we_cyc = -1; first_re_cyc = -1;
    bad_wdata = 0; first_re_addr = -1; last_re_addr = -1; last_we_addr = -1; busy_c0 = 0;
    lat = -1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      if (c == 0) busy_c0 = int'(a_busy);
      if (a_we) begin
        n_we++;
        last_we_cyc  = c;
        last_we_addr = int'(a_maddr);
        if (a_wdata !== (8'hA5 ^ {4'h0, a_maddr})) bad_wdata++;
      end
      if (a_agp) begin
        n_pre++;
        pre_cyc = c;
      end
      if (a_re) begin
        if (first_re_cyc < 0) begin
          first_re_cyc  = c;
          first_re_addr = int'(a_maddr);
        end
        n_re++;
        last_re_addr = int'(a_maddr);
      end
      if (a_done) begin
        lat = c;
        break;
      end
      start = (c == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; fault_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_pass, a_agr, a_agp, a_age, a_agud, a_we, a_re} !== 9'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {a_busy, a_done, a_pass, a_agr, a_agp, a_age, a_agud, a_we, a_re});
    end
    checks++;
    if (a_err !== 8'd0 || a_fea !== 4'd0) begin
      failures++;
      $display("FAIL reset_err: got err=%0d addr=%0d want 0/0", a_err, a_fea);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    int lat;
    fault_mode = 0;
    run_sweep(-1, lat);
    checks++;
    if (lat != 36) begin failures++; $display("FAIL clean_latency: got %0d want 36", lat); end
    checks++;
    if (a_pass !== 1'b1 || a_err !== 8'd0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_result: got pass=%b err=%0d busy=%b want 1/0/0", a_pass, a_err, a_busy);
    end
    checks++;
    if (busy_c0 != 1) begin failures++; $display("FAIL busy_rise: got %0d want 1", busy_c0); end
    checks++;
    if (n_we != 16 || bad_wdata != 0 || last_we_addr != 15) begin
      failures++;
      $display("FAIL writes: got n=%0d bad=%0d last=%0d want 16/0/15", n_we, bad_wdata, last_we_addr);
    end
    checks++;
    if (n_re != 16 || first_re_addr != 15 || last_re_addr != 0) begin
      failures++;
      $display("FAIL reads: got n=%0d first=%0d last=%0d want 16/15/0",
               n_re, first_re_addr, last_re_addr);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ram[i] !== (8'hA5 ^ 8'(i))) begin
        failures++;
        $display("FAIL ram_data[%0d]: got %h want %h", i, ram[i], 8'hA5 ^ 8'(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single_error();
    int lat;
    fault_mode = 1;
    run_sweep(-1, lat);
    checks++;
    if (lat != 36 || a_pass !== 1'b0 || a_err !== 8'd1 || a_fea !== 4'd9) begin
      failures++;
      $display("FAIL single_err: got lat=%0d pass=%b err=%0d addr=%0d want 36/0/1/9",
               lat, a_pass, a_err, a_fea);
    end
    fault_mode = 0;
  endtask

  task automatic test_all_zero();
    int lat;
    fault_mode = 2;
    @(negedge clk);
    run_sweep(-1, lat);
    checks++;
    if (lat != 36 || a_pass !== 1'b0 || a_err !== 8'd16 || a_fea !== 4'd15) begin
      failures++;
      $display("FAIL all_zero: got lat=%0d pass=%b err=%0d addr=%0d want 36/0/16/15",
               lat, a_pass, a_err, a_fea);
    end
    checks++;
    if (b_done !== 1'b1 || b_pass !== 1'b0 || b_err !== 3'd7 || b_fea !== 4'd15) begin
      failures++;
      $display("FAIL saturate_w3: got done=%b pass=%b err=%0d addr=%0d want 1/0/7/15",
               b_done, b_pass, b_err, b_fea);
    end
    fault_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_repulse_in_read();
    int lat;
    run_sweep(25, lat);
    checks++;
    if (lat != 36 || a_pass !== 1'b1) begin
      failures++;
      $display("FAIL repulse_read: got lat=%0d pass=%b want 36/1", lat, a_pass);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_from_done();
    int lat;
    fault_mode = 1;
    run_sweep(-1, lat);
    fault_mode = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_done_drop: got done=%b busy=%b want 0/1", a_done, a_busy);
    end
    @(negedge clk);
    checks++;
    if (a_err !== 8'd0 || a_fea !== 4'd0) begin
      failures++;
      $display("FAIL restart_clear: got err=%0d addr=%0d want 0/0", a_err, a_fea);
    end
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (a_done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0 || a_pass !== 1'b1) begin
      failures++;
      $display("FAIL restart_finish: got lat=%0d pass=%b want done with pass=1", lat, a_pass);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (a_we !== 1'b1 || a_maddr !== 4'd4) begin
      failures++;
      $display("FAIL write5_pos: got we=%b addr=%0d want 1/4", a_we, a_maddr);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({a_busy, a_done, a_pass, a_agr, a_agp, a_age, a_agud, a_we, a_re} !== 9'h0 ||
        a_err !== 8'd0 || a_fea !== 4'd0) begin
      failures++;
      $display("FAIL reset_abort: got ctrl=%b err=%0d addr=%0d want 0/0/0",
               {a_busy, a_done, a_pass, a_agr, a_agp, a_age, a_agud, a_we, a_re}, a_err, a_fea);
    end
    @(negedge clk);
    run_sweep(-1, lat);
    checks++;
    if (lat != 36 || a_pass !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_sweep: got lat=%0d pass=%b want 36/1", lat, a_pass);
    end
    @(negedge clk);
  endtask

  task automatic test_preset_window();
    int lat;
    run_sweep(-1, lat);
    checks++;
    if (n_pre != 1 || pre_cyc != last_we_cyc + 1 || first_re_cyc != pre_cyc + 1) begin
      failures++;
      $display("FAIL preset_window: got n=%0d pre=%0d last_we=%0d first_re=%0d want 1/17/16/18",
               n_pre, pre_cyc, last_we_cyc, first_re_cyc);
    end
    checks++;
    if (pre_cyc != 17) begin
      failures++;
      $display("FAIL preset_cycle: got %0d want 17", pre_cyc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_clean_sweep();
    test_single_error();
    test_all_zero();
    test_repulse_in_read();
    test_restart_from_done();
    test_reset_mid_write();
    test_preset_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
